reg_writeback: RTL and testbench
================================

// Module: reg_writeback
// PURPOSE
// - Write-side initiator for the 32x32 register file. Sits between execute/load-return and the regfile write port.
// - Merges two result sources into the single write port: ALU (always accepted) and load return (buffered, valid/ready).
// - Keeps a per-register busy scoreboard for issue-stage hazard checks. Writes to x0 never reach the regfile.
// PARAMETERS
// - XLEN       32  data width of results and of the write port
// - LDQ_DEPTH  4   load-return queue entries; power of 2, >=2
// PORTS
// - clk            in   1     clock
// - rst_n          in   1     async active-low reset
// - alu_valid_i    in   1     ALU result valid; always accepted, no ready
// - alu_rd_i       in   5     ALU destination register
// - alu_data_i     in   XLEN  ALU result
// - ld_valid_i     in   1     load result valid
// - ld_ready_o     out  1     load queue can accept (registered, = !full)
// - ld_rd_i        in   5     load destination register
// - ld_data_i      in   XLEN  load data
// - iss_valid_i    in   1     instruction issued with a destination
// - iss_rd_i       in   5     issued destination register
// - reg_busy_o     out  32    scoreboard; bit n = write to xn pending
// - reg_wr_data_o  out  XLEN  to regfile write data
// - reg_wr_reg_o   out  5     to regfile write register
// - ctrl_reg_we_o  out  1     to regfile write enable
// - fwd_rs1_i, fwd_rs2_i    in   5     forward lookup addrs (WB_FWD_EN only)
// - fwd_hit1_o, fwd_hit2_o  out  1     forward hit (WB_FWD_EN only)
// - fwd_data1_o, fwd_data2_o out XLEN  forward data (WB_FWD_EN only)
// BEHAVIOUR
// - Reset: we=0, wr_reg=0, wr_data=0, queue empty, ld_ready_o=1, reg_busy_o=0, fwd_hit*=0.
// - Write port is registered. A source selected in cycle N drives we/reg/data in cycle N+1 for exactly one cycle.
// - Priority per cycle: ALU first, then queue head, then bypass load (ld_valid_i&&ld_ready_o with queue empty).
// - Load handshake: accept when ld_valid_i && ld_ready_o. Accepted load enqueues unless it is written via bypass the same cycle.
// - ALU+load in same cycle: ALU is written at N+1. Load enqueues and is written no earlier than N+2.
// - Queue: FIFO order, simultaneous push+pop allowed at full. ld_ready_o deasserts the cycle after count reaches LDQ_DEPTH.
// - rd==0 from any source is consumed normally but drives ctrl_reg_we_o=0 and does not occupy a write slot.
// - Scoreboard: set bit iss_rd_i on iss_valid_i (never bit 0). Clear bit rd on the edge the write is registered.
// - Scoreboard: set and clear of the same rd on the same edge leaves the bit set (new producer wins).
// - Pointers wrap modulo LDQ_DEPTH. No overflow: a push while full is impossible by handshake. Assert in sim.
// - Reset mid-operation discards queued loads and clears the scoreboard. No partial write is issued after rst_n rises.
// CONFIGURATION
// - WB_FWD_EN defined: fwd_hitK_o = ctrl_reg_we_o && reg_wr_reg_o==fwd_rsK_i && fwd_rsK_i!=0. fwd_dataK_o = reg_wr_data_o.
//   This covers the regfile holding stale read data during its write cycle.
// - WB_FWD_EN undefined: fwd_* inputs ignored, fwd_hit*_o=0, fwd_data*_o=0, no compare logic.
// STRUCTURE
// - Shared package riscv_pkg: XLEN, REG_AW=5, REG_NUM=32, typedef wb_entry_t {logic [4:0] rd; logic [XLEN-1:0] data;}.
// - Sub-module wb_ldq: synchronous FIFO of wb_entry_t (push/pop/full/empty/head), depth LDQ_DEPTH.
// - Top contains: priority select, output register, scoreboard, forwarding compare.
// TESTING
// - Reset: assert rst_n=0 mid-stream with 3 queued loads -> we=0, reg_busy_o=0, ld_ready_o=1; no write after release.
// - ALU only: alu rd=5 data=0xDEADBEEF at N -> N+1: we=1, reg=5, data=0xDEADBEEF; N+2: we=0.
// - Collision: ALU rd=3 =0x11 and load rd=4 =0x22 at N -> N+1 writes x3=0x11, N+2 writes x4=0x22.
// - Backpressure: ALU valid every cycle, 5 loads offered -> ld_ready_o low after 4 accepted.
//   Drop ALU -> loads written in order, ready returns.
// - Scoreboard: issue rd=7 -> busy[7]=1. Same-edge issue rd=7 and ALU write rd=7 -> busy[7] stays 1. x0 issue -> busy[0]=0.
// - WB_FWD_EN: write x9=0xCAFE registered, fwd_rs1_i=9, fwd_rs2_i=0 -> hit1=1 data1=0xCAFE, hit2=0. Undefined build -> hits 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared register-file types and constants for the writeback path.
package riscv_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned REG_NUM = 32;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// Result-source, issue, regfile write and forwarding signals of reg_writeback.
// slave: the writeback block; master: the surrounding pipeline.
interface reg_writeback_if;
  import riscv_pkg::*;

  logic                 alu_valid_i;
  logic [REG_AW-1:0]    alu_rd_i;
  logic [XLEN-1:0]      alu_data_i;
  logic                 ld_valid_i;
  logic                 ld_ready_o;
  logic [REG_AW-1:0]    ld_rd_i;
  logic [XLEN-1:0]      ld_data_i;
  logic                 iss_valid_i;
  logic [REG_AW-1:0]    iss_rd_i;
  logic [REG_NUM-1:0]   reg_busy_o;
  logic [XLEN-1:0]      reg_wr_data_o;
  logic [REG_AW-1:0]    reg_wr_reg_o;
  logic                 ctrl_reg_we_o;
  logic [REG_AW-1:0]    fwd_rs1_i;
  logic [REG_AW-1:0]    fwd_rs2_i;
  logic                 fwd_hit1_o;
  logic                 fwd_hit2_o;
  logic [XLEN-1:0]      fwd_data1_o;
  logic [XLEN-1:0]      fwd_data2_o;

  modport slave (
    input  alu_valid_i, alu_rd_i, alu_data_i,
    input  ld_valid_i, ld_rd_i, ld_data_i,
    output ld_ready_o,
    input  iss_valid_i, iss_rd_i,
    output reg_busy_o,
    output reg_wr_data_o, reg_wr_reg_o, ctrl_reg_we_o,
    input  fwd_rs1_i, fwd_rs2_i,
    output fwd_hit1_o, fwd_hit2_o, fwd_data1_o, fwd_data2_o
  );

  modport master (
    output alu_valid_i, alu_rd_i, alu_data_i,
    output ld_valid_i, ld_rd_i, ld_data_i,
    input  ld_ready_o,
    output iss_valid_i, iss_rd_i,
    input  reg_busy_o,
    input  reg_wr_data_o, reg_wr_reg_o, ctrl_reg_we_o,
    output fwd_rs1_i, fwd_rs2_i,
    input  fwd_hit1_o, fwd_hit2_o, fwd_data1_o, fwd_data2_o
  );

endinterface

// File: rtl/wb_ldq.sv
// Load-return FIFO of wb_entry_t; Depth must be a power of two so pointers wrap naturally.
module wb_ldq
  import riscv_pkg::*;
#(
  parameter int unsigned Depth = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  wb_entry_t entry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      full_o,
  output logic      empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  wb_entry_t           mem_q [Depth];
  wb_entry_t           mem_d [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]       cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign full_o  = (cnt_q == (PtrW+1)'(Depth));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // A push at full is legal only when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = entry_i;
      wr_ptr_d        = wr_ptr_q + PtrW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + (PtrW+1)'(1);
      2'b01:   cnt_d = cnt_q - (PtrW+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(push_i && full_o && !pop_i));

endmodule

// File: rtl/reg_writeback.sv
// Merges ALU and load results onto the regfile write port and tracks pending writes.
// Optional forwarding of the in-flight write is enabled by defining WB_FWD_EN.
module reg_writeback
  import riscv_pkg::*;
#(
  parameter int unsigned LDQ_DEPTH = 4
) (
  input logic            clk,
  input logic            rst_n,
  reg_writeback_if.slave wb
);

  wb_entry_t          ldq_head;
  wb_entry_t          ldq_entry;
  logic               ldq_full, ldq_empty;
  logic               ldq_push, ldq_pop;
  logic               ld_live, alu_live, bypass;

  logic               we_q, we_d;
  logic [REG_AW-1:0]  wr_reg_q, wr_reg_d;
  logic [XLEN-1:0]    wr_data_q, wr_data_d;
  logic [REG_NUM-1:0] busy_q, busy_d;

  assign ldq_entry = '{rd: wb.ld_rd_i, data: wb.ld_data_i};

  wb_ldq #(
    .Depth (LDQ_DEPTH)
  ) u_ldq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (ldq_push),
    .entry_i (ldq_entry),
    .pop_i   (ldq_pop),
    .head_o  (ldq_head),
    .full_o  (ldq_full),
    .empty_o (ldq_empty)
  );

  // rd==0 results are consumed but never claim the write slot or a queue entry.
  assign alu_live = wb.alu_valid_i && (wb.alu_rd_i != '0);
  assign ld_live  = wb.ld_valid_i && !ldq_full && (wb.ld_rd_i != '0);

  always_comb begin
    we_d      = 1'b0;
    wr_reg_d  = '0;
    wr_data_d = '0;
    ldq_pop   = 1'b0;
    bypass    = 1'b0;
    if (alu_live) begin
      we_d      = 1'b1;
      wr_reg_d  = wb.alu_rd_i;
      wr_data_d = wb.alu_data_i;
    end else if (!ldq_empty) begin
      ldq_pop   = 1'b1;
      we_d      = 1'b1;
      wr_reg_d  = ldq_head.rd;
      wr_data_d = ldq_head.data;
    end else if (ld_live) begin
      bypass    = 1'b1;
      we_d      = 1'b1;
      wr_reg_d  = wb.ld_rd_i;
      wr_data_d = wb.ld_data_i;
    end
    ldq_push = ld_live && !bypass;
  end

  // Set after clear so a new producer issued on the write edge keeps the bit.
  always_comb begin
    busy_d = busy_q;
    if (we_d) begin
      busy_d[wr_reg_d] = 1'b0;
    end
    if (wb.iss_valid_i && (wb.iss_rd_i != '0)) begin
      busy_d[wb.iss_rd_i] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q      <= 1'b0;
      wr_reg_q  <= '0;
      wr_data_q <= '0;
      busy_q    <= '0;
    end else begin
      we_q      <= we_d;
      wr_reg_q  <= wr_reg_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
    end
  end

  assign wb.ld_ready_o    = !ldq_full;
  assign wb.ctrl_reg_we_o = we_q;
  assign wb.reg_wr_reg_o  = wr_reg_q;
  assign wb.reg_wr_data_o = wr_data_q;
  assign wb.reg_busy_o    = busy_q;

`ifdef WB_FWD_EN
  assign wb.fwd_hit1_o  = we_q && (wr_reg_q == wb.fwd_rs1_i) && (wb.fwd_rs1_i != '0);
  assign wb.fwd_hit2_o  = we_q && (wr_reg_q == wb.fwd_rs2_i) && (wb.fwd_rs2_i != '0);
  assign wb.fwd_data1_o = wr_data_q;
  assign wb.fwd_data2_o = wr_data_q;
`else
  logic unused_fwd;
  assign unused_fwd     = ^{wb.fwd_rs1_i, wb.fwd_rs2_i};
  assign wb.fwd_hit1_o  = 1'b0;
  assign wb.fwd_hit2_o  = 1'b0;
  assign wb.fwd_data1_o = '0;
  assign wb.fwd_data2_o = '0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Randomized and directed bench for reg_writeback against a queue-based model.
module tb_reg_writeback;
  import riscv_pkg::*;

  localparam int unsigned LdqDepth = 4;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_t;

  logic clk;
  logic rst_n;
  reg_writeback_if wbif ();

  reg_writeback #(
    .LDQ_DEPTH (LdqDepth)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wb    (wbif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_vec;
  int unsigned n_mis;

  // Model state: what the write port shows now, pending loads, pending-write bits.
  logic        exp_we;
  logic [4:0]  exp_reg;
  logic [31:0] exp_data;
  logic [31:0] mbusy;
  ld_t         mq[$];
  logic        last_acc;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_idle();
    wbif.alu_valid_i = 1'b0;
    wbif.alu_rd_i    = '0;
    wbif.alu_data_i  = '0;
    wbif.ld_valid_i  = 1'b0;
    wbif.ld_rd_i     = '0;
    wbif.ld_data_i   = '0;
    wbif.iss_valid_i = 1'b0;
    wbif.iss_rd_i    = '0;
    wbif.fwd_rs1_i   = '0;
    wbif.fwd_rs2_i   = '0;
  endtask

  task automatic model_clear();
    mq.delete();
    exp_we   = 1'b0;
    exp_reg  = '0;
    exp_data = '0;
    mbusy    = '0;
  endtask

  // One cycle: drive at negedge, check current outputs, then advance the model.
  task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                      input logic iv, input logic [4:0] ir,
                      input logic [4:0] f1, input logic [4:0] f2);
    logic        rdy, acc, nwe, byp;
    logic [4:0]  nreg;
    logic [31:0] ndata;
    ld_t         e;
    @(negedge clk);
    wbif.alu_valid_i = av;
    wbif.alu_rd_i    = ar;
    wbif.alu_data_i  = ad;
    wbif.ld_valid_i  = lv;
    wbif.ld_rd_i     = lr;
    wbif.ld_data_i   = ld;
    wbif.iss_valid_i = iv;
    wbif.iss_rd_i    = ir;
    wbif.fwd_rs1_i   = f1;
    wbif.fwd_rs2_i   = f2;
    #1;
    rdy = (mq.size() < LdqDepth);
    check_eq("we", wbif.ctrl_reg_we_o, exp_we);
    check_eq("wr_reg", wbif.reg_wr_reg_o, exp_reg);
    check_eq("wr_data", wbif.reg_wr_data_o, exp_data);
    check_eq("busy", wbif.reg_busy_o, mbusy);
    check_eq("ld_ready", wbif.ld_ready_o, rdy);
`ifdef WB_FWD_EN
    check_eq("fwd_hit1", wbif.fwd_hit1_o, exp_we && exp_reg == f1 && f1 != 0);
    check_eq("fwd_hit2", wbif.fwd_hit2_o, exp_we && exp_reg == f2 && f2 != 0);
    check_eq("fwd_data1", wbif.fwd_data1_o, exp_data);
    check_eq("fwd_data2", wbif.fwd_data2_o, exp_data);
`else
    check_eq("fwd_hit1", wbif.fwd_hit1_o, 0);
    check_eq("fwd_hit2", wbif.fwd_hit2_o, 0);
    check_eq("fwd_data1", wbif.fwd_data1_o, 0);
    check_eq("fwd_data2", wbif.fwd_data2_o, 0);
`endif
    acc   = lv && rdy;
    nwe   = 1'b0;
    nreg  = '0;
    ndata = '0;
    byp   = 1'b0;
    if (av && ar != 0) begin
      nwe = 1'b1; nreg = ar; ndata = ad;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      nwe = 1'b1; nreg = e.rd; ndata = e.data;
    end else if (acc && lr != 0) begin
      nwe = 1'b1; nreg = lr; ndata = ld; byp = 1'b1;
    end
    if (acc && lr != 0 && !byp) mq.push_back('{rd: lr, data: ld});
    if (nwe) mbusy[nreg] = 1'b0;
    if (iv && ir != 0) mbusy[ir] = 1'b1;
    exp_we   = nwe;
    exp_reg  = nreg;
    exp_data = ndata;
    last_acc = acc;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic mid_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_eq("rst_we", wbif.ctrl_reg_we_o, 0);
    check_eq("rst_busy", wbif.reg_busy_o, 0);
    check_eq("rst_ready", wbif.ld_ready_o, 1);
    @(negedge clk);
    check_eq("rst_hold_we", wbif.ctrl_reg_we_o, 0);
    rst_n = 1'b1;
    model_clear();
    idle_cycles(4);
  endtask

  initial begin
    logic av, lv, iv;
    logic [4:0] ar, lr, ir;
    n_vec    = 0;
    n_mis    = 0;
    last_acc = 1'b0;
    rst_n    = 1'b0;
    drive_idle();
    model_clear();
    #2;
    check_eq("reset_we", wbif.ctrl_reg_we_o, 0);
    check_eq("reset_reg", wbif.reg_wr_reg_o, 0);
    check_eq("reset_data", wbif.reg_wr_data_o, 0);
    check_eq("reset_ready", wbif.ld_ready_o, 1);
    check_eq("reset_busy", wbif.reg_busy_o, 0);
    check_eq("reset_hit1", wbif.fwd_hit1_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ALU only.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("alu_we", wbif.ctrl_reg_we_o, 1);
    check_eq("alu_reg", wbif.reg_wr_reg_o, 5);
    check_eq("alu_data", wbif.reg_wr_data_o, 32'hDEADBEEF);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("alu_we_off", wbif.ctrl_reg_we_o, 0);

    // ALU and load collide: ALU first, load one cycle later.
    step(1, 3, 32'h11, 1, 4, 32'h22, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("col_reg1", wbif.reg_wr_reg_o, 3);
    check_eq("col_data1", wbif.reg_wr_data_o, 32'h11);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("col_reg2", wbif.reg_wr_reg_o, 4);
    check_eq("col_data2", wbif.reg_wr_data_o, 32'h22);
    idle_cycles(2);

    // Backpressure: ALU every cycle, five loads offered.
    for (int i = 0; i < 5; i++) step(1, 5'(20 + i), 32'(i), 1, 5'(10 + i), 32'(100 + i),
                                     0, 0, 0, 0);
    step(1, 25, 32'h55, 1, 14, 32'd104, 0, 0, 0, 0);
    check_eq("bp_ready_low", wbif.ld_ready_o, 0);
    last_acc = 1'b0;
    for (int g = 0; g < 20 && !last_acc; g++) step(0, 0, 0, 1, 14, 32'd104, 0, 0, 0, 0);
    idle_cycles(8);
    check_eq("bp_ready_back", wbif.ld_ready_o, 1);

    // Scoreboard set, same-edge set/clear, x0 issue.
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("sb_set7", wbif.reg_busy_o[7], 1);
    step(1, 7, 32'h77, 0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    check_eq("sb_keep7", wbif.reg_busy_o[7], 1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    check_eq("sb_x0", wbif.reg_busy_o[0], 0);

    // Forwarding of the registered write.
    step(1, 9, 32'hCAFE, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 0);
`ifdef WB_FWD_EN
    check_eq("fwd_x9_hit1", wbif.fwd_hit1_o, 1);
    check_eq("fwd_x9_data1", wbif.fwd_data1_o, 32'hCAFE);
`else
    check_eq("fwd_x9_hit1", wbif.fwd_hit1_o, 0);
`endif
    check_eq("fwd_x9_hit2", wbif.fwd_hit2_o, 0);

    // Reset with three queued loads.
    for (int i = 0; i < 3; i++) step(1, 5'(1 + i), 32'(i), 1, 5'(16 + i), 32'(200 + i),
                                     0, 0, 0, 0);
    step(1, 6, 32'h66, 0, 0, 0, 1, 12, 0, 0);
    mid_reset();

    // Random traffic.
    for (int c = 0; c < 2500; c++) begin
      av = ($urandom_range(0, 99) < 45);
      lv = ($urandom_range(0, 99) < 55);
      iv = ($urandom_range(0, 99) < 40);
      ar = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      lr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      ir = 5'($urandom_range(0, 31));
      step(av, ar, $urandom, lv, lr, $urandom, iv, ir,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
      if (c == 1200) mid_reset();
    end
    idle_cycles(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
